adc_scan_sequencer: RTL and testbench

Scheduler that time-shares the single 12-bit SPI ADC engine across up to NUM_CH input channels. On each sample tick it walks the enabled channels in ascending order, starts one SPI conversion per channel, and stores each result in a per-channel register bank. It sits between the clock prescaler/SPI state machine and the display/LED consumers. Consumers read the bank through a registered read port or take the per-sample strobe.

---
 rtl/adc_scan_sequencer.sv | 178 +++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: on each sample tick, scans the enabled channels in ascending order through one SPI ADC engine.
// Optional macro ADC_AVG_EN: the bank keeps a two-point running average instead of the raw sample.
module adc_scan_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int DATA_W     = 12,
  parameter int SAMPLE_DIV = 10000,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              clr_err,
  input  logic              spi_busy,
  input  logic              spi_data_valid,
  input  logic [DATA_W-1:0] spi_data,
  output logic              spi_start,
  output logic [CH_W-1:0]   spi_channel,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_ch,
  output logic [DATA_W-1:0] sample_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              scan_done,
  output logic              busy,
  output logic              overrun_err,
  output logic              timeout_err
);
  // state       | meaning
  // S_IDLE      | waiting for a sample tick with a non-empty channel mask
  // S_ISSUE     | waiting for the SPI engine to be free, then pulse spi_start
  // S_WAIT_DONE | conversion in flight, timeout down-counter running
  // S_STORE     | write captured result into the bank
  // S_NEXT      | advance to the next enabled channel or finish the scan
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_STORE, S_NEXT} state_t;

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [NUM_CH-1:0] scan_mask, scan_mask_nxt;
  logic [CH_W-1:0]   cur_ch, cur_ch_nxt;
  logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
  logic [DATA_W-1:0] cap_data, cap_nxt;
  logic [DATA_W-1:0] bank [NUM_CH];
  logic [DATA_W-1:0] wr_val;
  logic [CH_W:0]     first_hit, next_hit;
  logic              start_nxt, done_nxt, bank_we, timeout_set, overrun_set;

  // Returns {found, index} of the lowest set bit of m at or above position lo.
  function automatic logic [CH_W:0] find_bit(input logic [NUM_CH-1:0] m, input int lo);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && i >= lo) r = {1'b1, CH_W'(i)};
    return r;
  endfunction

  assign tick        = enable && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign busy        = (state != S_IDLE);
  assign spi_channel = cur_ch;
  assign overrun_set = tick && (state != S_IDLE);

  always_comb begin
    state_nxt     = state;
    scan_mask_nxt = scan_mask;
    cur_ch_nxt    = cur_ch;
    tmo_nxt       = tmo_cnt;
    cap_nxt       = cap_data;
    start_nxt     = 1'b0;
    done_nxt      = 1'b0;
    bank_we       = 1'b0;
    timeout_set   = 1'b0;
    first_hit     = find_bit(ch_mask, 0);
    next_hit      = find_bit(scan_mask, int'(cur_ch) + 1);
    case (state)
      S_IDLE: begin
        if (tick && first_hit[CH_W]) begin
          scan_mask_nxt = ch_mask;
          cur_ch_nxt    = first_hit[CH_W-1:0];
          state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!spi_busy) begin
          start_nxt = 1'b1;
          tmo_nxt   = TMO_W'(TIMEOUT - 1);
          state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (spi_data_valid) begin
          cap_nxt   = spi_data;
          state_nxt = S_STORE;
        end else if (tmo_cnt == '0) begin
          timeout_set = 1'b1;
          state_nxt   = S_NEXT;
        end else begin
          tmo_nxt = tmo_cnt - 1'b1;
        end
      end
      S_STORE: begin
        bank_we   = 1'b1;
        state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (next_hit[CH_W]) begin
          cur_ch_nxt = next_hit[CH_W-1:0];
          state_nxt  = S_ISSUE;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef ADC_AVG_EN
  logic [NUM_CH-1:0] seen;

  always_ff @(posedge clk) begin
    if (reset) seen <= '0;
    else if (bank_we) seen[cur_ch] <= 1'b1;
  end

  // First sample of a channel seeds the average directly.
  always_comb
    wr_val = seen[cur_ch] ? DATA_W'(({1'b0, bank[cur_ch]} + {1'b0, cap_data}) >> 1) : cap_data;
`else
  always_comb wr_val = cap_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      scan_mask    <= '0;
      cur_ch       <= '0;
      tmo_cnt      <= '0;
      cap_data     <= '0;
      spi_start    <= 1'b0;
      scan_done    <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      rd_data      <= '0;
      overrun_err  <= 1'b0;
      timeout_err  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
    end else begin
      state     <= state_nxt;
      scan_mask <= scan_mask_nxt;
      cur_ch    <= cur_ch_nxt;
      tmo_cnt   <= tmo_nxt;
      cap_data  <= cap_nxt;
      if (!enable || tick) div_cnt <= '0;
      else div_cnt <= div_cnt + 1'b1;
      spi_start    <= start_nxt;
      scan_done    <= done_nxt;
      sample_valid <= bank_we;
      if (bank_we) begin
        bank[cur_ch] <= wr_val;
        sample_ch    <= cur_ch;
        sample_data  <= wr_val;
      end
      rd_data <= (int'(rd_ch) < NUM_CH) ? bank[rd_ch] : '0;
      // A flag being set in the same cycle as clr_err stays set.
      if (overrun_set) overrun_err <= 1'b1;
      else if (clr_err) overrun_err <= 1'b0;
      if (timeout_set) timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer: SPI responder, event monitor and a queue-based reference model.
module tb_adc_scan_sequencer;
  localparam int NUM_CH = 4, CH_W = 2, DATA_W = 12, SAMPLE_DIV = 20, TIMEOUT = 10;

  logic clk = 1'b0;
  logic reset, enable, clr_err;
  logic [NUM_CH-1:0] ch_mask;
  logic spi_busy, spi_data_valid;
  logic [DATA_W-1:0] spi_data;
  logic spi_start, sample_valid, scan_done, busy, overrun_err, timeout_err;
  logic [CH_W-1:0] spi_channel, sample_ch, rd_ch;
  logic [DATA_W-1:0] sample_data, rd_data;

  logic m_busy, m_valid, force_busy, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  assign spi_busy       = m_busy | force_busy;
  assign spi_data_valid = m_valid | s_valid;
  assign spi_data       = s_valid ? s_data : m_data;

  always #5 clk = ~clk;

  adc_scan_sequencer #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W),
                       .SAMPLE_DIV(SAMPLE_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .clr_err(clr_err),
    .spi_busy(spi_busy), .spi_data_valid(spi_data_valid), .spi_data(spi_data),
    .spi_start(spi_start), .spi_channel(spi_channel), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data), .rd_ch(rd_ch), .rd_data(rd_data),
    .scan_done(scan_done), .busy(busy), .overrun_err(overrun_err), .timeout_err(timeout_err));

  typedef struct {int ch; int data;} smp_t;

  int n_cmp = 0, n_fail = 0;
  logic [NUM_CH-1:0] mute = '0;
  bit spi_fixed = 1'b1;
  int spi_dly = 5;
  logic [DATA_W-1:0] force_vals [2];
  int force_lim = 0;

  smp_t sent_q[$], samp_q[$];
  int start_q[$];
  int done_cnt = 0, busy_cycles = 0;
  int start_rd = 0, samp_rd = 0, sent_rd = 0, done_rd = 0;
  int bank_m [NUM_CH];
  bit seen_m [NUM_CH];

  // Behavioural SPI engine: answers each unmuted start after a delay with chosen data.
  initial begin : spi_model
    int ch, dly, f_used;
    logic [DATA_W-1:0] d;
    m_busy = 1'b0; m_valid = 1'b0; m_data = '0; f_used = 0;
    forever begin
      @(posedge clk); #1;
      if (spi_start === 1'b1 && !mute[spi_channel]) begin
        ch = int'(spi_channel);
        if (f_used < force_lim) begin d = force_vals[f_used]; f_used++; end
        else if (spi_fixed) d = 12'(12'h100 + ch);
        else d = 12'($urandom);
        dly = spi_fixed ? spi_dly : int'($urandom_range(1, 7));
        m_busy = 1'b1;
        repeat (dly) begin @(posedge clk); #1; end
        m_data = d; m_valid = 1'b1; m_busy = 1'b0;
        sent_q.push_back('{ch: ch, data: int'(d)});
        @(posedge clk); #1;
        m_valid = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      if (spi_start === 1'b1) start_q.push_back(int'(spi_channel));
      if (sample_valid === 1'b1) samp_q.push_back('{ch: int'(sample_ch), data: int'(sample_data)});
      if (scan_done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cycles++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic want, input int budget, input string tag, output int k);
    k = 0;
    while (busy !== want && k < budget) begin step(); k++; end
    check(tag, 32'(busy), 32'(want));
  endtask

  task automatic start_scan(input logic [NUM_CH-1:0] m, input string tag, output int k);
    ch_mask = m;
    enable  = 1'b1;
    wait_busy(1'b1, SAMPLE_DIV + 5, tag, k);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    wait_busy(1'b0, 400, tag, k);
    step(); step();
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (spi_start !== 1'b1 && k < 50) begin step(); k++; end
    check(tag, 32'(spi_start), 32'd1);
  endtask

  task automatic read_all(input string tag);
    for (int c = 0; c < NUM_CH; c++) begin
      rd_ch = CH_W'(c);
      step();
      check($sformatf("%s_rd%0d", tag, c), 32'(rd_data), 32'(bank_m[c]));
    end
  endtask

  task automatic reset_model();
    for (int c = 0; c < NUM_CH; c++) begin bank_m[c] = 0; seen_m[c] = 1'b0; end
  endtask

  // Expected scan: starts on every set mask bit in ascending order, one sample per answered conversion.
  task automatic verify_scan(input logic [NUM_CH-1:0] m, input string tag);
    int exp_ch[$];
    int ns, na;
    for (int c = 0; c < NUM_CH; c++) if (m[c]) exp_ch.push_back(c);
    check({tag, "_nstart"}, start_q.size() - start_rd, exp_ch.size());
    foreach (exp_ch[i])
      if (start_rd + i < start_q.size())
        check($sformatf("%s_start%0d", tag, i), start_q[start_rd + i], exp_ch[i]);
    start_rd = start_q.size();
    na = $countones(m & ~mute);
    ns = sent_q.size() - sent_rd;
    check({tag, "_nsamp"}, samp_q.size() - samp_rd, na);
    for (int i = 0; i < ns; i++) begin
      smp_t s;
      int v;
      s = sent_q[sent_rd + i];
`ifdef ADC_AVG_EN
      v = seen_m[s.ch] ? (bank_m[s.ch] + s.data) / 2 : s.data;
`else
      v = s.data;
`endif
      seen_m[s.ch] = 1'b1;
      bank_m[s.ch] = v;
      if (samp_rd + i < samp_q.size()) begin
        check($sformatf("%s_sch%0d", tag, i), samp_q[samp_rd + i].ch, s.ch);
        check($sformatf("%s_sdat%0d", tag, i), samp_q[samp_rd + i].data, v);
      end
    end
    sent_rd = sent_q.size();
    samp_rd = samp_q.size();
    check({tag, "_done"}, done_cnt - done_rd, (m != '0) ? 1 : 0);
    done_rd = done_cnt;
  endtask

  initial begin : main
    int k, j, bc;
    logic [NUM_CH-1:0] m;
    reset = 1'b1; enable = 1'b0; ch_mask = '0; clr_err = 1'b0; rd_ch = '0;
    force_busy = 1'b0; s_valid = 1'b0; s_data = '0;
    reset_model();
    repeat (3) step();
    reset = 1'b0;
    step();

    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(spi_start), 0);
    check("rst_chan", 32'(spi_channel), 0);
    check("rst_svalid", 32'(sample_valid), 0);
    check("rst_sdata", 32'(sample_data), 0);
    check("rst_done", 32'(scan_done), 0);
    check("rst_ovr", 32'(overrun_err), 0);
    check("rst_tmo", 32'(timeout_err), 0);
    read_all("rst");

    // Fixed responder: 5-cycle latency, data 0x100+ch.
    start_scan(4'b1011, "t1_busy", k);
    check("t1_tick_period", k, SAMPLE_DIV);
    enable = 1'b0;
    wait_idle("t1_idle");
    if (samp_q.size() - samp_rd == 3) begin
      check("t1_s0", samp_q[samp_rd].data, 'h100);
      check("t1_s1", samp_q[samp_rd + 1].data, 'h101);
      check("t1_s2", samp_q[samp_rd + 2].data, 'h103);
    end
    verify_scan(4'b1011, "t1");
    rd_ch = 2'd3;
    step();
    check("t1_rd3", 32'(rd_data), 32'h103);

    // Empty mask: ticks happen but nothing starts.
    bc = busy_cycles;
    ch_mask = '0;
    enable = 1'b1;
    repeat (100) step();
    enable = 1'b0;
    step();
    check("t2_nstart", start_q.size() - start_rd, 0);
    check("t2_done", done_cnt - done_rd, 0);
    check("t2_busy", busy_cycles - bc, 0);

    // SPI engine busy for 30 cycles at scan start.
    spi_fixed = 1'b0;
    force_busy = 1'b1;
    start_scan(4'b0110, "t3_busy", k);
    enable = 1'b0;
    repeat (30) step();
    check("t3_held", start_q.size() - start_rd, 0);
    check("t3_still_busy", 32'(busy), 1);
    force_busy = 1'b0;
    wait_idle("t3_idle");
    verify_scan(4'b0110, "t3");
    check("t3_tmo", 32'(timeout_err), 0);

    // Channel 0 never answers.
    mute = 4'b0001;
    start_scan(4'b0011, "t4_busy", k);
    enable = 1'b0;
    wait_start("t4_start");
    j = 0;
    while (timeout_err !== 1'b1 && j < 20) begin step(); j++; end
    check("t4_tmo_delay", j, TIMEOUT);
    wait_idle("t4_idle");
    verify_scan(4'b0011, "t4");
    check("t4_tmo_sticky", 32'(timeout_err), 1);
    check("t4_ovr", 32'(overrun_err), 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t4_tmo_clr", 32'(timeout_err), 0);
    mute = '0;

    // Long scan overlaps the next tick; clr_err collides with the overrun set.
    spi_fixed = 1'b1;
    spi_dly = 8;
    start_scan(4'b1111, "t5_busy", k);
    repeat (SAMPLE_DIV - 1) step();
    check("t5_ovr_pre", 32'(overrun_err), 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t5_ovr_setwins", 32'(overrun_err), 1);
    enable = 1'b0;
    wait_idle("t5_idle");
    verify_scan(4'b1111, "t5");
    check("t5_ovr_sticky", 32'(overrun_err), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t5_ovr_clr", 32'(overrun_err), 0);

    // Random masks, data and latencies.
    spi_fixed = 1'b0;
    for (int it = 0; it < 6; it++) begin
      m = 4'($urandom_range(1, 15));
      start_scan(m, $sformatf("r%0d_busy", it), k);
      enable = 1'b0;
      wait_idle($sformatf("r%0d_idle", it));
      verify_scan(m, $sformatf("r%0d", it));
    end
    read_all("rand");

    // Stray data-valid while idle is ignored.
    s_data = 12'($urandom);
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    repeat (3) step();
    check("stray_nsamp", samp_q.size() - samp_rd, 0);
    read_all("stray");

    // Reset during a conversion.
    mute = 4'b1111;
    start_scan(4'b1111, "t6_busy", k);
    enable = 1'b0;
    wait_start("t6_start");
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_busy_after_rst", 32'(busy), 0);
    start_rd = start_q.size();
    done_rd = done_cnt;
    reset_model();
    repeat (10) step();
    check("t6_nstart", start_q.size() - start_rd, 0);
    check("t6_done", done_cnt - done_rd, 0);
    read_all("t6_bank");
    mute = '0;

    // Two samples 0x200 then 0x100 on channel 0.
    spi_fixed = 1'b1;
    spi_dly = 3;
    force_vals[0] = 12'h200;
    force_vals[1] = 12'h100;
    force_lim = 2;
    start_scan(4'b0001, "t6a_busy", k);
    enable = 1'b0;
    wait_idle("t6a_idle");
    if (samp_q.size() > samp_rd) check("t6a_val", samp_q[$].data, 'h200);
    verify_scan(4'b0001, "t6a");
    start_scan(4'b0001, "t6b_busy", k);
    enable = 1'b0;
    wait_idle("t6b_idle");
`ifdef ADC_AVG_EN
    if (samp_q.size() > samp_rd) check("t6b_val", samp_q[$].data, 'h180);
`else
    if (samp_q.size() > samp_rd) check("t6b_val", samp_q[$].data, 'h100);
`endif
    verify_scan(4'b0001, "t6b");
    read_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
